// File: rtl/sid_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : sid_wr_sched
// Brief    : Two-requester round-robin write queue that issues SID register
//            writes paced by ce_1m. Define SID_WR_SHADOW_EN for shadow read-back.
// Revision : 1.0  initial release
// ============================================================================
module sid_wr_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP        = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ce_1m,
    input  logic                          a_req,
    input  logic [4:0]                    a_addr,
    input  logic [7:0]                    a_data,
    output logic                          a_ack,
    input  logic                          b_req,
    input  logic [4:0]                    b_addr,
    input  logic [7:0]                    b_data,
    output logic                          b_ack,
    output logic                          sid_we,
    output logic [4:0]                    sid_addr,
    output logic [7:0]                    sid_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic [7:0]                    drop_cnt
`ifdef SID_WR_SHADOW_EN
    ,
    input  logic [4:0]                    rd_addr,
    output logic [7:0]                    rd_data
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [4:0] MAX_REG = 5'h18;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      gap_q, gap_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [12:0]     mem_q [FIFO_DEPTH];
    logic            rr_q;           // 0: A favoured on contention, 1: B favoured
    logic            a_ack_q, b_ack_q;
    logic            sid_we_q;
    logic [4:0]      sid_addr_q;
    logic [7:0]      sid_data_q;
    logic [7:0]      drop_cnt_q;

    logic            a_elig, b_elig;
    logic            pop, can_push, push;
    logic            grant_a, grant_b;
    logic [12:0]     push_word;
    logic [12:0]     head;
    logic            head_legal;

    always_comb begin
        a_elig     = a_req & ~a_ack_q;
        b_elig     = b_req & ~b_ack_q;
        head       = mem_q[rd_ptr_q];
        head_legal = (head[12:8] <= MAX_REG);
        pop        = (state_q == S_IDLE) && (level_q != '0) && ce_1m;
        // A pop on the same edge frees a slot, so a full queue can still accept
        can_push   = (level_q != LW'(FIFO_DEPTH)) || pop;
        grant_a    = can_push && a_elig && (!b_elig || !rr_q);
        grant_b    = can_push && b_elig && (!a_elig ||  rr_q);
        push       = grant_a || grant_b;
        push_word  = grant_a ? {a_addr, a_data} : {b_addr, b_data};
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (pop && head_legal) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (GAP == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    gap_d   = 4'(GAP);
                end
            end
            S_WAIT: begin
                if (ce_1m) begin
                    gap_d = gap_q - 4'd1;
                    if (gap_q <= 4'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rr_q     <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
        end else begin
            a_ack_q <= grant_a;
            b_ack_q <= grant_b;
            if (grant_a) begin
                rr_q <= 1'b1;
            end else if (grant_b) begin
                rr_q <= 1'b0;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Queue storage carries no reset; pointers and level define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sid_we_q   <= 1'b0;
            sid_addr_q <= '0;
            sid_data_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            sid_we_q <= pop && head_legal;
            if (pop && head_legal) begin
                sid_addr_q <= head[12:8];
                sid_data_q <= head[7:0];
            end
            if (pop && !head_legal && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

`ifdef SID_WR_SHADOW_EN
    logic [7:0] shadow_q [25];
    logic       pw_hi;

    // Pulse-width high registers only implement their low nibble
    assign pw_hi = (sid_addr_q == 5'h03) || (sid_addr_q == 5'h0A) || (sid_addr_q == 5'h11);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 25; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (sid_we_q) begin
            shadow_q[sid_addr_q] <= pw_hi ? {4'h0, sid_data_q[3:0]} : sid_data_q;
        end
    end

    assign rd_data = (rd_addr <= MAX_REG) ? shadow_q[rd_addr] : 8'h00;
`endif

    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign sid_we     = sid_we_q;
    assign sid_addr   = sid_addr_q;
    assign sid_data   = sid_data_q;
    assign fifo_level = level_q;
    assign busy       = (level_q != '0) || (state_q != S_IDLE);
    assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire
